axil_ctrl_responder: RTL and testbench
======================================

Name: axil_ctrl_responder

Overview:
AXI4-Lite responder (slave) that terminates the host PCIe AXI-Lite control master and implements a small memory-mapped control/status register file. It is the target-side counterpart of the PCIe control initiator and sits in the top level between the PCIe block-design AXI-Lite master port and fabric logic that needs host-programmable registers, such as QSFP link control and debug counters. It supports one outstanding write and one outstanding read, independent AW/W acceptance, byte strobes, and SLVERR on out-of-range addresses.

Parameters:
ADDR_WIDTH, 25, width of awaddr/araddr; only bits [log2(NUM_REGS)+1:0] plus the range check are used
DATA_WIDTH, 32, register and bus data width; fixed at 32
NUM_REGS, 16, number of 32-bit registers; must be a power of 2 and at least 2
ID_VALUE, 32'hF1E5_0001, constant returned by register 0, which is read-only

Ports:
clock  in  1  single clock for all logic
resetn  in  1  asynchronous, active-low reset
s_axil_awvalid / s_axil_awready  in/out  1/1  write-address handshake
s_axil_awaddr  in  ADDR_WIDTH  byte write address
s_axil_awprot  in  3  ignored
s_axil_wvalid / s_axil_wready  in/out  1/1  write-data handshake
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  byte enables
s_axil_bvalid / s_axil_bready  out/in  1/1  write-response handshake
s_axil_bresp  out  2  write response: 00 OKAY, 10 SLVERR
s_axil_arvalid / s_axil_arready  in/out  1/1  read-address handshake
s_axil_araddr  in  ADDR_WIDTH  byte read address
s_axil_arprot  in  3  ignored
s_axil_rvalid / s_axil_rready  out/in  1/1  read-data handshake
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
ctrl_regs  out  NUM_REGS*32  flattened register contents; register i occupies bits [32i+31:32i]
wr_pulse  out  NUM_REGS  one-cycle pulse on bit i when register i is written with OKAY

Behaviour:
- Reset (resetn low, asynchronous):
  - registers 1..NUM_REGS-1 = 0; aw_held = 0, w_held = 0
  - bvalid = 0, rvalid = 0, bresp = 00, rresp = 00, rdata = 0, wr_pulse = 0
  - awready, wready and arready read 0 while resetn is low
- Reset mid-transaction drops any pending handshake state; no response is issued after reset.
- Address decode:
  - idx = addr[log2(NUM_REGS)+1:2]; addr[1:0] is ignored
  - in range iff addr[ADDR_WIDTH-1:log2(NUM_REGS)+2] == 0
- Write path, FSM states W_IDLE and W_RESP:
  - W_IDLE: awready = !aw_held; wready = !w_held
  - An AW handshake captures the address into aw_held; a W handshake captures data and strb into w_held. The two may arrive in either order or in the same cycle.
  - On the edge where both are held, or become held: commit, clear both held flags, set bvalid = 1, go to W_RESP. No bubble when AW and W arrive together: bvalid is high the cycle after that handshake.
  - Commit when in range and idx != 0: byte k of reg[idx] is updated iff strb[k]; bresp = 00; wr_pulse[idx] = 1 for exactly the cycle in which bvalid first rises.
  - Commit with idx == 0: no update, bresp = 00, no pulse.
  - Commit with strb == 0: no update, bresp = 00, pulse still fires.
  - Commit when out of range: no update, bresp = 10, no pulse.
  - W_RESP: awready = wready = 0; bvalid and bresp are held stable until bready; on bvalid && bready, return to W_IDLE.
- Read path, FSM states R_IDLE and R_RESP:
  - R_IDLE: arready = 1. On AR handshake, rdata = reg[idx] (or ID_VALUE for idx 0), rresp = 00 or 10, rvalid = 1 on the next cycle, go to R_RESP.
  - Out-of-range reads return rdata = 0, rresp = 10.
  - R_RESP: arready = 0; rdata and rresp are held stable until rready; then return to R_IDLE.
- Read and write paths are fully independent. If a read is accepted on the same edge that a write commits to the same register, the read returns the pre-write value.
- The valid outputs never depend combinationally on the ready inputs.
- ctrl_regs is registered and reflects a write the cycle after commit.

Test Plan:
- Write, same-cycle AW+W: AW addr 0x8 and W data 0xDEADBEEF, strb 0xF, in one cycle -> bvalid next cycle, bresp 00, wr_pulse[2] for 1 cycle, ctrl_regs[95:64] = 0xDEADBEEF.
- Split W-before-AW with partial strobe: W data 0x11223344, strb 0x5 at cycle 0; AW addr 0x8 at cycle 3 -> bvalid at cycle 4, reg2 = 0xDE22BE44; wready low during cycles 1-3.
- Read ID and back-pressure: AR 0x0 with rready held low for 5 cycles -> rvalid held, rdata = 0xF1E50001 stable, arready 0 until rready; then a write to 0x0 -> bresp 00, reg0 unchanged.
- Out-of-range address: AW/W to 0x40 with NUM_REGS = 16 -> bresp 10, no wr_pulse, no register changes; AR 0x1000 -> rresp 10, rdata 0.
- Concurrent read and write: AR 0xC on the same edge as a write commit of 0x5 to 0xC (old value 0x7) -> rdata 0x7, next read returns 0x5.
- Reset mid-write: AW held, W not yet sent, resetn pulsed low -> after release aw_held = 0, bvalid = 0, all registers 0; a fresh full write completes normally.

Source files
------------

// File: rtl/axil_ctrl_responder_if.sv
// AXI4-Lite control bus bundle shared by the PCIe control master and the
// register-file responder.
interface axil_ctrl_responder_if #(
    parameter int unsigned ADDR_WIDTH = 25,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_ctrl_responder.sv
// AXI4-Lite responder exposing a small host-programmable register file;
// register 0 is a read-only ID, out-of-range accesses return SLVERR.
module axil_ctrl_responder #(
    parameter int unsigned ADDR_WIDTH = 25,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16,
    parameter logic [31:0] ID_VALUE   = 32'hF1E5_0001
) (
    input  logic                           clock,
    input  logic                           resetn,
    axil_ctrl_responder_if.slave           s_axil,
    output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_regs,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int unsigned IW = $clog2(NUM_REGS);
    localparam int unsigned NB = DATA_WIDTH / 8;

    typedef logic [IW-1:0] idx_t;
    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_RESP } r_state_t;

    w_state_t                w_state;
    r_state_t                r_state;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    logic                    aw_held;
    logic                    w_held;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [NB-1:0]           w_strb_q;

    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic                    rvalid_q;
    logic [1:0]              rresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic [DATA_WIDTH-1:0]   c_data;
    logic [NB-1:0]           c_strb;
    idx_t                    c_idx;
    idx_t                    ar_idx;
    logic                    unused_bits;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:IW+2] == '0;
    endfunction

    assign s_axil.awready = resetn && (w_state == W_IDLE) && !aw_held;
    assign s_axil.wready  = resetn && (w_state == W_IDLE) && !w_held;
    assign s_axil.arready = resetn && (r_state == R_IDLE);
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rdata_q;

    assign aw_hs = s_axil.awvalid && s_axil.awready;
    assign w_hs  = s_axil.wvalid && s_axil.wready;
    assign ar_hs = s_axil.arvalid && s_axil.arready;

    // A beat arriving this cycle is used directly so AW+W together commit with no bubble.
    always_comb begin
        c_addr = aw_held ? aw_addr_q : s_axil.awaddr;
        c_data = w_held ? w_data_q : s_axil.wdata;
        c_strb = w_held ? w_strb_q : s_axil.wstrb;
        c_idx  = c_addr[IW+1:2];
        ar_idx = s_axil.araddr[IW+1:2];
        commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    end

    assign unused_bits = ^{s_axil.awprot, s_axil.arprot, c_addr[1:0], s_axil.araddr[1:0]};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            wr_pulse  <= '0;
            regs[0]   <= ID_VALUE;
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_pulse <= '0;
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held   <= 1'b1;
                        aw_addr_q <= s_axil.awaddr;
                    end
                    if (w_hs) begin
                        w_held   <= 1'b1;
                        w_data_q <= s_axil.wdata;
                        w_strb_q <= s_axil.wstrb;
                    end
                    if (commit) begin
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        bvalid_q <= 1'b1;
                        w_state  <= W_RESP;
                        if (!in_range(c_addr)) begin
                            bresp_q <= 2'b10;
                        end else begin
                            bresp_q <= 2'b00;
                            if (c_idx != '0) begin
                                wr_pulse[c_idx] <= 1'b1;
                                for (int unsigned k = 0; k < NB; k++) begin
                                    if (c_strb[k]) begin
                                        regs[c_idx][8*k +: 8] <= c_data[8*k +: 8];
                                    end
                                end
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (s_axil.bready) begin
                        bvalid_q <= 1'b0;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Reads sample regs before this edge's write lands, giving pre-write data on a collision.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= 2'b00;
            rdata_q  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rvalid_q <= 1'b1;
                        r_state  <= R_RESP;
                        if (in_range(s_axil.araddr)) begin
                            rdata_q <= regs[ar_idx];
                            rresp_q <= 2'b00;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= 2'b10;
                        end
                    end
                end
                R_RESP: begin
                    if (s_axil.rready) begin
                        rvalid_q <= 1'b0;
                        r_state  <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl_regs = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            ctrl_regs[DATA_WIDTH*i +: DATA_WIDTH] = regs[i];
        end
    end
endmodule

// File: tb/tb_axil_ctrl_responder.sv
// Directed and randomized bench for axil_ctrl_responder against a
// register-array reference model.
module tb_axil_ctrl_responder;
    localparam int unsigned NR = 16;
    localparam logic [31:0] ID = 32'hF1E5_0001;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    axil_ctrl_responder_if #(.ADDR_WIDTH(25), .DATA_WIDTH(32)) bus ();
    logic [NR*32-1:0] ctrl_regs;
    logic [NR-1:0]    wr_pulse;

    axil_ctrl_responder #(
        .ADDR_WIDTH(25), .DATA_WIDTH(32), .NUM_REGS(NR), .ID_VALUE(ID)
    ) dut (
        .clock(clock), .resetn(resetn), .s_axil(bus),
        .ctrl_regs(ctrl_regs), .wr_pulse(wr_pulse)
    );

    logic [31:0] model [NR];
    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mflat();
        logic [511:0] f;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    function automatic bit inr(input logic [24:0] a);
        return a[24:6] == 19'd0;
    endfunction

    task automatic model_reset();
        model[0] = ID;
        for (int i = 1; i < NR; i++) model[i] = 32'd0;
    endtask

    task automatic wr(input logic [24:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int order, input int gap);
        int idx;
        logic [15:0] epulse;
        logic [1:0] eresp;
        int stall;
        idx = int'(a[5:2]);
        epulse = '0;
        eresp = inr(a) ? 2'b00 : 2'b10;
        @(negedge clock);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = (order != 1);
        bus.wvalid  = (order != 2);
        @(negedge clock);
        if (order != 0) begin
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            for (int g = 0; g <= gap; g++) begin
                if (order == 1) chk("wready_held", 512'(bus.wready), 512'(0));
                else            chk("awready_held", 512'(bus.awready), 512'(0));
                chk("bvalid_early", 512'(bus.bvalid), 512'(0));
                if (g < gap) @(negedge clock);
            end
            if (order == 1) bus.awvalid = 1'b1; else bus.wvalid = 1'b1;
            @(negedge clock);
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (inr(a) && idx != 0) begin
            epulse[idx] = 1'b1;
            for (int k = 0; k < 4; k++)
                if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
        end
        chk("bvalid", 512'(bus.bvalid), 512'(1));
        chk("bresp", 512'(bus.bresp), 512'(eresp));
        chk("wr_pulse", 512'(wr_pulse), 512'(epulse));
        chk("ctrl_regs", ctrl_regs, mflat());
        stall = $urandom_range(0, 2);
        for (int t = 0; t < stall; t++) begin
            @(negedge clock);
            chk("bvalid_stall", 512'(bus.bvalid), 512'(1));
            chk("bresp_stall", 512'(bus.bresp), 512'(eresp));
            chk("awready_resp", 512'(bus.awready), 512'(0));
        end
        bus.bready = 1'b1;
        @(negedge clock);
        bus.bready = 1'b0;
        chk("bvalid_done", 512'(bus.bvalid), 512'(0));
        chk("wr_pulse_done", 512'(wr_pulse), 512'(0));
    endtask

    task automatic rd(input logic [24:0] a, input int stall);
        logic [31:0] ed;
        logic [1:0]  er;
        ed = inr(a) ? model[int'(a[5:2])] : 32'd0;
        er = inr(a) ? 2'b00 : 2'b10;
        @(negedge clock);
        bus.araddr = a; bus.arvalid = 1'b1;
        chk("arready_idle", 512'(bus.arready), 512'(1));
        @(negedge clock);
        bus.arvalid = 1'b0;
        chk("rvalid", 512'(bus.rvalid), 512'(1));
        chk("rdata", 512'(bus.rdata), 512'(ed));
        chk("rresp", 512'(bus.rresp), 512'(er));
        for (int t = 0; t < stall; t++) begin
            @(negedge clock);
            chk("rvalid_stall", 512'(bus.rvalid), 512'(1));
            chk("rdata_stall", 512'(bus.rdata), 512'(ed));
            chk("arready_resp", 512'(bus.arready), 512'(0));
        end
        bus.rready = 1'b1;
        @(negedge clock);
        bus.rready = 1'b0;
        chk("rvalid_done", 512'(bus.rvalid), 512'(0));
        chk("arready_back", 512'(bus.arready), 512'(1));
    endtask

    initial begin
        logic [24:0] ra;
        bus.awvalid = 0; bus.awaddr = '0; bus.awprot = '0;
        bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = '0; bus.arprot = '0; bus.rready = 0;
        model_reset();

        repeat (2) @(negedge clock);
        chk("rst_awready", 512'(bus.awready), 512'(0));
        chk("rst_wready", 512'(bus.wready), 512'(0));
        chk("rst_arready", 512'(bus.arready), 512'(0));
        chk("rst_bvalid", 512'(bus.bvalid), 512'(0));
        chk("rst_rvalid", 512'(bus.rvalid), 512'(0));
        chk("rst_bresp", 512'(bus.bresp), 512'(0));
        chk("rst_rresp", 512'(bus.rresp), 512'(0));
        chk("rst_rdata", 512'(bus.rdata), 512'(0));
        chk("rst_wr_pulse", 512'(wr_pulse), 512'(0));
        chk("rst_ctrl_regs", ctrl_regs, mflat());
        resetn = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", 512'({bus.awready, bus.wready, bus.arready}), 512'(3'b111));

        wr(25'h8, 32'hDEADBEEF, 4'hF, 0, 0);
        wr(25'h8, 32'h11223344, 4'h5, 1, 2);
        chk("reg2_partial", 512'(ctrl_regs[95:64]), 512'(32'hDE22BE44));
        rd(25'h0, 5);
        wr(25'h0, 32'h12345678, 4'hF, 2, 1);
        rd(25'h0, 0);
        wr(25'h40, 32'hCAFEF00D, 4'hF, 0, 0);
        rd(25'h1000, 1);
        wr(25'h14, 32'hAABBCCDD, 4'h0, 0, 0);
        wr(25'h3F, 32'h5555AAAA, 4'hF, 2, 0);
        rd(25'h3C, 0);

        wr(25'hC, 32'h7, 4'hF, 0, 0);
        @(negedge clock);
        bus.awaddr = 25'hC; bus.wdata = 32'h5; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1;
        bus.araddr = 25'hC; bus.arvalid = 1;
        @(negedge clock);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        chk("collide_rdata", 512'(bus.rdata), 512'(32'h7));
        chk("collide_bvalid", 512'(bus.bvalid), 512'(1));
        model[3] = 32'h5;
        chk("collide_regs", ctrl_regs, mflat());
        bus.bready = 1; bus.rready = 1;
        @(negedge clock);
        bus.bready = 0; bus.rready = 0;
        chk("collide_done", 512'({bus.bvalid, bus.rvalid}), 512'(0));
        rd(25'hC, 0);

        @(negedge clock);
        bus.awaddr = 25'h10; bus.awvalid = 1;
        @(negedge clock);
        bus.awvalid = 0;
        chk("aw_held", 512'({bus.awready, bus.wready}), 512'(2'b01));
        resetn = 1'b0;
        #1;
        chk("midrst_ready", 512'({bus.awready, bus.wready, bus.arready}), 512'(0));
        model_reset();
        chk("midrst_regs", ctrl_regs, mflat());
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("relrst_awready", 512'(bus.awready), 512'(1));
        chk("relrst_bvalid", 512'(bus.bvalid), 512'(0));
        bus.wdata = 32'h99; bus.wstrb = 4'hF; bus.wvalid = 1;
        @(negedge clock);
        bus.wvalid = 0;
        chk("relrst_no_commit", 512'({bus.bvalid, wr_pulse}), 512'(0));
        bus.awaddr = 25'h10; bus.awvalid = 1;
        @(negedge clock);
        bus.awvalid = 0;
        model[4] = 32'h99;
        chk("fresh_bvalid", 512'(bus.bvalid), 512'(1));
        chk("fresh_regs", ctrl_regs, mflat());
        bus.bready = 1;
        @(negedge clock);
        bus.bready = 0;
        wr(25'h18, 32'h0BADF00D, 4'hF, 0, 0);

        for (int it = 0; it < 60; it++) begin
            ra = 25'($urandom_range(0, 63));
            if ($urandom_range(0, 9) >= 8) ra[$urandom_range(6, 24)] = 1'b1;
            if ($urandom_range(0, 1) == 0)
                wr(ra, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 2), $urandom_range(0, 3));
            else
                rd(ra, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
